divisor_restaurador: RTL and testbench
======================================

Name: divisor_restaurador

Overview:
- Sequential restoring (shift-subtract) unsigned divider; the inverse of the datapath's shift-add multiplier.
- Computes cociente = dividendo / divisor and residuo = dividendo % divisor, one quotient bit per clock.
- Self-contained: internal partial-remainder register, quotient shift register, iteration counter and control FSM.
- Sits beside the multiplier in the arithmetic datapath; uses the same start/done style of operation request.

Parameters:
- ANCHO, 8, operand and result width in bits (ANCHO >= 2).
- CONT_ANCHO, $clog2(ANCHO)+1, iteration counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- dividendo  input  ANCHO  unsigned dividend; captured on the accepted start edge.
- divisor  input  ANCHO  unsigned divisor; captured on the accepted start edge.
- cociente  output  ANCHO  registered quotient; held until the next result is written.
- residuo  output  ANCHO  registered remainder; held until the next result is written.
- done  output  1  high for exactly one cycle when a result is valid (state FIN).
- busy  output  1  high whenever state != IDLE.
- div_cero  output  1  registered flag; set with the result of a divide-by-zero, cleared on the next accepted start.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; cociente, residuo, R, Q, counter = 0; done = busy = div_cero = 0. Reset wins over every other condition, including mid-operation; the partial result is discarded and the outputs read 0.
- States: IDLE, CALC, FIN.
- IDLE, start=0: hold.
- IDLE, start=1, divisor != 0: capture Q = dividendo, D = divisor, R = 0 (ANCHO+1 bits), counter = ANCHO, div_cero = 0; go to CALC.
- IDLE, start=1, divisor == 0: go directly to FIN. Write cociente = all ones, residuo = dividendo, div_cero = 1.
- CALC, every edge:
  - {R,Q} shifted left one bit; t = R_shifted - {1'b0,D}, computed in ANCHO+1 bits.
  - If t MSB = 0: R = t, Q[0] = 1. Otherwise keep R_shifted (restore), Q[0] = 0.
  - counter decrements by 1.
  - On the edge where counter goes from 1 to 0: write cociente = final Q, residuo = R[ANCHO-1:0]; go to FIN.
- FIN: done=1 for this single cycle, then IDLE on the next edge unconditionally.
- start is ignored while busy; it is not queued. If start is still high when the block returns to IDLE, it is accepted on the following edge.
- Latency:
  - Normal operation: start accepted at edge E0; iterations occur on edges E1..E(ANCHO); done is high during the cycle after E(ANCHO). That is ANCHO+1 cycles from E0, and a new start can be accepted at E(ANCHO+2).
  - Divide by zero: done is high in the cycle right after E0.
- cociente and residuo do not change during CALC; they keep the previous result. Inputs may change freely after E0.
- Invariant for every non-zero divisor: cociente*divisor + residuo == dividendo and residuo < divisor.
- Edge cases:
  - dividendo = 0 gives 0, 0.
  - divisor > dividendo gives cociente 0, residuo = dividendo.
  - divisor = 1 gives cociente = dividendo, residuo 0.
  - No overflow is possible: the quotient always fits in ANCHO bits.

Test Plan:
- Reset, then start with dividendo=100, divisor=7 (ANCHO=8) -> busy=1 for 9 cycles; done pulses exactly once in the 9th cycle after the start edge; cociente=14, residuo=2, div_cero=0.
- dividendo=255/1, then 5/9, then 0/3, run back to back with start held high -> results 255/0, 0/5, 0/0; each done pulse is separated by 10 cycles; outputs hold between operations.
- dividendo=200, divisor=0 -> done in the cycle after start; cociente=255, residuo=200, div_cero=1. The next op 200/10 gives 20/0 with div_cero=0.
- Pulse start again during CALC with different operands -> ignored; the first result (100/7 -> 14, 2) is unchanged and only one done pulse occurs.
- Assert rst at the 4th CALC cycle of 250/3 -> all outputs 0 and state IDLE on the next edge; a new 250/3 request then completes with 83/1.
- Random sweep of 1000 ops with ANCHO=8 and ANCHO=4 -> the invariant holds for every op; done width is always 1 cycle and latency is always ANCHO+1.

Source files
------------

// File: rtl/divisor_restaurador_if.sv
// Operation bus of the restoring divider: request side (start, operands)
// and result side (quotient, remainder, status).
interface divisor_restaurador_if #(
  parameter int ANCHO = 8
);
  logic             start;
  logic [ANCHO-1:0] dividendo;
  logic [ANCHO-1:0] divisor;
  logic [ANCHO-1:0] cociente;
  logic [ANCHO-1:0] residuo;
  logic             done;
  logic             busy;
  logic             div_cero;

  // Requester: issues operations and reads results.
  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, done, busy, div_cero
  );

  // Divider: accepts operations and produces results.
  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, done, busy, div_cero
  );
endinterface

// File: rtl/divisor_restaurador.sv
// Sequential restoring (shift-subtract) unsigned divider.
// One quotient bit per clock; divide-by-zero short-circuits to FIN with
// quotient all ones, remainder = dividend and div_cero set.
module divisor_restaurador #(
  parameter int ANCHO      = 8,
  parameter int CONT_ANCHO = $clog2(ANCHO) + 1
) (
  input logic                  clk,
  input logic                  rst,
  divisor_restaurador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

  estado_t estado_r;
  estado_t estado_s;

  // The restored partial remainder is always < divisor, so it fits in ANCHO
  // bits; the extra bit only exists in the shifted/subtracted intermediate.
  logic [ANCHO-1:0]      r_r;
  logic [ANCHO-1:0]      q_r;
  logic [ANCHO-1:0]      d_r;
  logic [CONT_ANCHO-1:0] cnt_r;

  logic [ANCHO-1:0]      cociente_r;
  logic [ANCHO-1:0]      residuo_r;
  logic                  done_r;
  logic                  busy_r;
  logic                  div_cero_r;

  logic [ANCHO:0]        r_desp_s;
  logic [ANCHO:0]        resta_s;
  logic [ANCHO-1:0]      r_sig_s;
  logic [ANCHO-1:0]      q_sig_s;
  logic                  acepta_s;
  logic                  cero_s;
  logic                  ultimo_s;

  // One shift-subtract step and next-state decode.
  always_comb begin
    estado_s = estado_r;
    acepta_s = 1'b0;
    ultimo_s = 1'b0;
    cero_s   = (bus.divisor == {ANCHO{1'b0}});
    r_desp_s = {r_r, q_r[ANCHO-1]};
    resta_s  = r_desp_s - {1'b0, d_r};
    if (resta_s[ANCHO] == 1'b0) begin
      r_sig_s = resta_s[ANCHO-1:0];
      q_sig_s = {q_r[ANCHO-2:0], 1'b1};
    end else begin
      r_sig_s = r_desp_s[ANCHO-1:0];
      q_sig_s = {q_r[ANCHO-2:0], 1'b0};
    end
    case (estado_r)
      IDLE: begin
        if (bus.start) begin
          acepta_s = 1'b1;
          if (cero_s) begin
            estado_s = FIN;
          end else begin
            estado_s = CALC;
          end
        end else begin
          estado_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CONT_ANCHO'(1)) begin
          ultimo_s = 1'b1;
          estado_s = FIN;
        end else begin
          estado_s = CALC;
        end
      end
      FIN:     estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= IDLE;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Datapath, result registers and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r        <= {ANCHO{1'b0}};
      q_r        <= {ANCHO{1'b0}};
      d_r        <= {ANCHO{1'b0}};
      cnt_r      <= {CONT_ANCHO{1'b0}};
      cociente_r <= {ANCHO{1'b0}};
      residuo_r  <= {ANCHO{1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      div_cero_r <= 1'b0;
    end else begin
      done_r <= (estado_s == FIN);
      busy_r <= (estado_s != IDLE);
      if (acepta_s) begin
        if (cero_s) begin
          cociente_r <= {ANCHO{1'b1}};
          residuo_r  <= bus.dividendo;
          div_cero_r <= 1'b1;
        end else begin
          q_r        <= bus.dividendo;
          d_r        <= bus.divisor;
          r_r        <= {ANCHO{1'b0}};
          cnt_r      <= CONT_ANCHO'(ANCHO);
          div_cero_r <= 1'b0;
        end
      end else if (estado_r == CALC) begin
        r_r   <= r_sig_s;
        q_r   <= q_sig_s;
        cnt_r <= cnt_r - CONT_ANCHO'(1);
        if (ultimo_s) begin
          cociente_r <= q_sig_s;
          residuo_r  <= r_sig_s;
        end
      end
    end
  end

  assign bus.cociente = cociente_r;
  assign bus.residuo  = residuo_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.div_cero = div_cero_r;

endmodule

// File: tb/tb_divisor_restaurador.sv
// Self-checking bench for divisor_restaurador: directed scenarios on an
// 8-bit instance plus a randomized sweep on 8-bit and 4-bit instances,
// checked against plain integer division.
module tb_divisor_restaurador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  divisor_restaurador_if #(.ANCHO(8)) if8 ();
  divisor_restaurador_if #(.ANCHO(4)) if4 ();

  divisor_restaurador #(.ANCHO(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
  divisor_restaurador #(.ANCHO(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  task automatic test_reset();
    if8.start = 1'b0; if8.dividendo = 8'd0; if8.divisor = 8'd0;
    if4.start = 1'b0; if4.dividendo = 4'd0; if4.divisor = 4'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (if8.cociente !== 8'd0) begin n_fail++; $display("FAIL reset_cociente got %0d expected 0", if8.cociente); end
    n_chk++; if (if8.residuo !== 8'd0) begin n_fail++; $display("FAIL reset_residuo got %0d expected 0", if8.residuo); end
    n_chk++; if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.div_cero !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got done=%b busy=%b dz=%b expected 0 0 0", if8.done, if8.busy, if8.div_cero); end
    n_chk++; if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.cociente !== 4'd0) begin
      n_fail++; $display("FAIL reset_u4 got done=%b busy=%b q=%0d expected 0 0 0", if4.done, if4.busy, if4.cociente); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basico();
    int busy_n = 0; int done_n = 0; int done_c = 0;
    if8.dividendo = 8'd100; if8.divisor = 8'd7; if8.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) if8.start = 1'b0;
      if (if8.busy) busy_n++;
      if (if8.done) begin done_n++; done_c = c; end
      if (c == 5) begin
        n_chk++; if (if8.cociente !== 8'd0) begin n_fail++; $display("FAIL basico_hold_calc got %0d expected 0", if8.cociente); end
      end
    end
    n_chk++; if (busy_n != 9) begin n_fail++; $display("FAIL basico_busy_cycles got %0d expected 9", busy_n); end
    n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL basico_done_pulses got %0d expected 1", done_n); end
    n_chk++; if (done_c != 9) begin n_fail++; $display("FAIL basico_latency got %0d expected 9", done_c); end
    n_chk++; if (if8.cociente !== 8'(100 / 7)) begin n_fail++; $display("FAIL basico_cociente got %0d expected %0d", if8.cociente, 100 / 7); end
    n_chk++; if (if8.residuo !== 8'(100 % 7)) begin n_fail++; $display("FAIL basico_residuo got %0d expected %0d", if8.residuo, 100 % 7); end
    n_chk++; if (if8.div_cero !== 1'b0) begin n_fail++; $display("FAIL basico_div_cero got %b expected 0", if8.div_cero); end
  endtask

  task automatic test_back_to_back();
    int a[3] = '{255, 5, 0};
    int b[3] = '{1, 9, 3};
    int dc[3] = '{0, 0, 0};
    logic [7:0] gq[3]; logic [7:0] gr[3];
    int k = 0;
    if8.dividendo = 8'(a[0]); if8.divisor = 8'(b[0]); if8.start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1)  begin if8.dividendo = 8'(a[1]); if8.divisor = 8'(b[1]); end
      if (c == 11) begin if8.dividendo = 8'(a[2]); if8.divisor = 8'(b[2]); end
      if (c == 21) if8.start = 1'b0;
      if (if8.done && k < 3) begin dc[k] = c; gq[k] = if8.cociente; gr[k] = if8.residuo; k++; end
      if (c == 15) begin
        n_chk++; if (if8.cociente !== 8'(a[0] / b[0]) || if8.residuo !== 8'(a[0] % b[0])) begin
          n_fail++; $display("FAIL b2b_hold got %0d/%0d expected %0d/%0d", if8.cociente, if8.residuo, a[0] / b[0], a[0] % b[0]); end
      end
    end
    n_chk++; if (k != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d expected 3", k); end
    for (int i = 0; i < k; i++) begin
      n_chk++; if (gq[i] !== 8'(a[i] / b[i]) || gr[i] !== 8'(a[i] % b[i])) begin
        n_fail++; $display("FAIL b2b_result%0d got %0d/%0d expected %0d/%0d", i, gq[i], gr[i], a[i] / b[i], a[i] % b[i]); end
    end
    for (int i = 1; i < k; i++) begin
      n_chk++; if (dc[i] - dc[i-1] != 10) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d expected 10", i, dc[i] - dc[i-1]); end
    end
  endtask

  task automatic test_div_cero();
    int done_c = 0;
    if8.dividendo = 8'd200; if8.divisor = 8'd0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    n_chk++; if (if8.done !== 1'b1) begin n_fail++; $display("FAIL dz_done got %b expected 1", if8.done); end
    n_chk++; if (if8.cociente !== 8'd255 || if8.residuo !== 8'd200) begin
      n_fail++; $display("FAIL dz_result got %0d/%0d expected 255/200", if8.cociente, if8.residuo); end
    n_chk++; if (if8.div_cero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b expected 1", if8.div_cero); end
    @(negedge clk);
    n_chk++; if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin
      n_fail++; $display("FAIL dz_one_cycle got done=%b busy=%b expected 0 0", if8.done, if8.busy); end
    if8.dividendo = 8'd200; if8.divisor = 8'd10; if8.start = 1'b1;
    for (int c = 1; c <= 20 && done_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if8.start = 1'b0;
        n_chk++; if (if8.div_cero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start got %b expected 0", if8.div_cero); end
      end
      if (if8.done) done_c = c;
    end
    n_chk++; if (done_c != 9) begin n_fail++; $display("FAIL dz_next_latency got %0d expected 9", done_c); end
    n_chk++; if (if8.cociente !== 8'd20 || if8.residuo !== 8'd0) begin
      n_fail++; $display("FAIL dz_next_result got %0d/%0d expected 20/0", if8.cociente, if8.residuo); end
    @(negedge clk);
  endtask

  task automatic test_start_ignorado();
    int done_n = 0;
    if8.dividendo = 8'd100; if8.divisor = 8'd7; if8.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) if8.start = 1'b0;
      if (c == 3) begin if8.start = 1'b1; if8.dividendo = 8'd50; if8.divisor = 8'd3; end
      if (c == 4) if8.start = 1'b0;
      if (if8.done) done_n++;
    end
    n_chk++; if (done_n != 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d expected 1", done_n); end
    n_chk++; if (if8.cociente !== 8'd14 || if8.residuo !== 8'd2) begin
      n_fail++; $display("FAIL ignore_result got %0d/%0d expected 14/2", if8.cociente, if8.residuo); end
  endtask

  task automatic test_reset_medio();
    int done_c = 0;
    if8.dividendo = 8'd250; if8.divisor = 8'd3; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (if8.cociente !== 8'd0 || if8.residuo !== 8'd0) begin
      n_fail++; $display("FAIL midrst_result got %0d/%0d expected 0/0", if8.cociente, if8.residuo); end
    n_chk++; if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.div_cero !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got done=%b busy=%b dz=%b expected 0 0 0", if8.done, if8.busy, if8.div_cero); end
    if8.start = 1'b1;
    for (int c = 1; c <= 20 && done_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) if8.start = 1'b0;
      if (if8.done) done_c = c;
    end
    n_chk++; if (done_c != 9) begin n_fail++; $display("FAIL midrst_latency got %0d expected 9", done_c); end
    n_chk++; if (if8.cociente !== 8'd83 || if8.residuo !== 8'd1) begin
      n_fail++; $display("FAIL midrst_result2 got %0d/%0d expected 83/1", if8.cociente, if8.residuo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int op = 0; op < 1000; op++) begin
      int a8 = int'($urandom_range(0, 255));
      int b8 = (op % 40 == 0) ? 0 : int'($urandom_range(0, 255));
      int a4 = int'($urandom_range(0, 15));
      int b4 = (op % 40 == 7) ? 0 : int'($urandom_range(0, 15));
      int eq8 = (b8 == 0) ? 255 : a8 / b8;
      int er8 = (b8 == 0) ? a8 : a8 % b8;
      int eq4 = (b4 == 0) ? 15 : a4 / b4;
      int er4 = (b4 == 0) ? a4 : a4 % b4;
      int el8 = (b8 == 0) ? 1 : 9;
      int el4 = (b4 == 0) ? 1 : 5;
      int dn8 = 0; int dc8 = 0; int dn4 = 0; int dc4 = 0;
      if8.dividendo = 8'(a8); if8.divisor = 8'(b8); if8.start = 1'b1;
      if4.dividendo = 4'(a4); if4.divisor = 4'(b4); if4.start = 1'b1;
      for (int c = 1; c <= 13; c++) begin
        @(negedge clk);
        if (c == 1) begin
          if8.start = 1'b0; if4.start = 1'b0;
          if8.dividendo = 8'($urandom); if8.divisor = 8'($urandom);
          if4.dividendo = 4'($urandom); if4.divisor = 4'($urandom);
        end
        if (if8.done) begin dn8++; if (dc8 == 0) dc8 = c; end
        if (if4.done) begin dn4++; if (dc4 == 0) dc4 = c; end
      end
      n_chk++; if (dn8 != 1 || dc8 != el8) begin
        n_fail++; $display("FAIL rnd8_timing op%0d got pulses=%0d cycle=%0d expected 1 %0d", op, dn8, dc8, el8); end
      n_chk++; if (if8.cociente !== 8'(eq8) || if8.residuo !== 8'(er8) || if8.div_cero !== (b8 == 0)) begin
        n_fail++; $display("FAIL rnd8_result op%0d %0d/%0d got %0d,%0d,%b expected %0d,%0d,%b",
                           op, a8, b8, if8.cociente, if8.residuo, if8.div_cero, eq8, er8, b8 == 0); end
      if (b8 != 0) begin
        n_chk++; if (int'(if8.cociente) * b8 + int'(if8.residuo) != a8 || int'(if8.residuo) >= b8) begin
          n_fail++; $display("FAIL rnd8_invariant op%0d %0d/%0d got %0d,%0d", op, a8, b8, if8.cociente, if8.residuo); end
      end
      n_chk++; if (dn4 != 1 || dc4 != el4) begin
        n_fail++; $display("FAIL rnd4_timing op%0d got pulses=%0d cycle=%0d expected 1 %0d", op, dn4, dc4, el4); end
      n_chk++; if (if4.cociente !== 4'(eq4) || if4.residuo !== 4'(er4) || if4.div_cero !== (b4 == 0)) begin
        n_fail++; $display("FAIL rnd4_result op%0d %0d/%0d got %0d,%0d,%b expected %0d,%0d,%b",
                           op, a4, b4, if4.cociente, if4.residuo, if4.div_cero, eq4, er4, b4 == 0); end
      if (b4 != 0) begin
        n_chk++; if (int'(if4.cociente) * b4 + int'(if4.residuo) != a4 || int'(if4.residuo) >= b4) begin
          n_fail++; $display("FAIL rnd4_invariant op%0d %0d/%0d got %0d,%0d", op, a4, b4, if4.cociente, if4.residuo); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basico();
    test_back_to_back();
    test_div_cero();
    test_start_ignorado();
    test_reset_medio();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
